aud_capture_buffer: RTL and testbench
=====================================

Name: aud_capture_buffer

Overview:
- Record-path stage between the audio codec sample stream and the RAM write port of the recorder.
- Absorbs 16-bit samples arriving on the codec sample strobe in a small FIFO.
- Drains the FIFO into sequential RAM addresses whenever the memory interface reports ready.
- Exposes fill level, overflow and memory-full status for PicoBlaze input ports.

Parameters:
- DATA_W, 16: sample/RAM word width.
- DEPTH, 16: FIFO entries; must be a power of 2, minimum 4.
- ADDR_W, 26: RAM address width.
- MAX_ADDR, 26'h3FFFFFF: last writable RAM address.

Ports:
- clk  in  1  system clock (50 MHz domain)
- pb_reset  in  1  asynchronous, active-high reset
- record_en  in  1  level; enables sample capture into the FIFO
- addr_clear  in  1  level; returns write address to 0 and clears sticky flags
- sample_valid  in  1  one-cycle pulse per codec sample (sample_end)
- sample_in  in  DATA_W  sample, valid when sample_valid=1
- ram_rdy  in  1  memory interface ready for a command
- ram_we  out  1  one-cycle write-enable pulse to the memory interface
- ram_addr  out  ADDR_W  write address, valid while ram_we=1
- ram_data  out  DATA_W  write data, valid while ram_we=1
- cur_addr  out  ADDR_W  next address to be written
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; a sample was dropped
- mem_full  out  1  MAX_ADDR has been written

Behaviour:
- Reset (asynchronous, pb_reset=1): all outputs 0, FIFO empty, pointers 0, state IDLE.
- Push rule:
  - Push on sample_valid & record_en & level<DEPTH.
  - If sample_valid & record_en & level==DEPTH, the sample is dropped and overflow is set to 1.
  - record_en=0 ignores sample_valid; the FIFO keeps draining.
- FIFO:
  - Circular buffer with wrapping read/write pointers; level = pushes − pops.
  - A simultaneous push and pop leaves level unchanged.
  - A push is allowed when full only if a pop occurs in the same cycle (level stays at DEPTH, no overflow).
- FSM states: IDLE, ISSUE, FULL.
  - IDLE:
    - If addr_clear: cur_addr←0, overflow←0, stay IDLE; no pop this cycle.
    - Else if level>0 & ram_rdy: pop head into ram_data, ram_addr←cur_addr, ram_we←1, go ISSUE.
    - Else stay.
  - ISSUE (exactly one cycle):
    - ram_we←0.
    - If cur_addr==MAX_ADDR: mem_full←1, go FULL; cur_addr holds, no wrap.
    - Else cur_addr←cur_addr+1, go IDLE.
  - FULL:
    - No pops; the FIFO fills and later samples set overflow.
    - On addr_clear: cur_addr←0, mem_full←0, overflow←0, go IDLE.
- Latency: with an empty FIFO, IDLE state and ram_rdy=1, sample_valid at edge E0 gives ram_we high in the cycle after E1 and low after E2.
  - Maximum drain rate is one word per 2 clocks.
- addr_clear does not discard FIFO contents; queued samples are written from address 0 onward.
- addr_clear asserted during ISSUE takes effect on the next IDLE or FULL cycle.
- ram_rdy dropping during ISSUE has no effect; the command was already issued.
- ram_addr and ram_data hold their last values while ram_we=0.

Optional Feature:
- Macro: AUD_CAPTURE_PEAK_EN.
- With the macro defined:
  - Adds output peak_abs [DATA_W-1:0], reset 0.
  - On every accepted push, peak_abs←max(peak_abs, |sample_in|) with sample_in treated as two's complement.
  - |−32768| saturates to 16'h7FFF.
  - Cleared by addr_clear in IDLE or FULL.
- Without the macro: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package aud_rec_pkg holds:
  - AUD_DATA_W=16 and RAM_ADDR_W=26 constants;
  - the capture FSM state enum (IDLE, ISSUE, FULL);
  - the PicoBlaze port IDs for level, overflow and mem_full.
- Sub-module aud_sync_fifo (DATA_W, DEPTH) is natural: push, pop, dout, level, full, empty.
- Top handles drop/overflow logic, the FSM and address generation.

Test Plan:
- Reset: pb_reset pulse mid-ISSUE → ram_we=0, cur_addr=0, level=0, overflow=0, mem_full=0 immediately.
- Single sample: ram_rdy=1, record_en=1, one pulse with sample_in=16'h1234 → one ram_we pulse, ram_addr=0, ram_data=16'h1234, then cur_addr=1, level=0.
- Backpressure and overflow:
  - Hold ram_rdy=0 and send 17 samples 16'h0001..16'h0011 → level=16, overflow=1, sample 16'h0011 dropped.
  - Release ram_rdy → 16 writes to addresses 0..15 with data 1..16 in order.
- Memory full: MAX_ADDR=26'd3 with 6 samples → writes at 0..3, mem_full=1, state FULL, level=2; then addr_clear → next writes at addresses 0 and 1.
- Simultaneous push/pop: sample_valid aligned with the IDLE pop at level=16 → no overflow, level stays 16.
- Peak (AUD_CAPTURE_PEAK_EN): samples 16'h0100, 16'hFE00, 16'h8000 → peak_abs = 16'h0100, then 16'h0200, then 16'h7FFF.

Source files
------------

// File: rtl/aud_rec_pkg.sv
// aud_rec_pkg: shared constants, capture FSM states and PicoBlaze port IDs for the recorder.
package aud_rec_pkg;
   localparam int AUD_DATA_W = 16;
   localparam int RAM_ADDR_W = 26;
   typedef enum logic [1:0] {IDLE, ISSUE, FULL} cap_state_t;
   localparam logic [7:0] PB_PORT_LEVEL    = 8'h20;
   localparam logic [7:0] PB_PORT_OVERFLOW = 8'h21;
   localparam logic [7:0] PB_PORT_MEM_FULL = 8'h22;
endpackage

// File: rtl/aud_sync_fifo.sv
// aud_sync_fifo: first-word-fall-through circular FIFO with occupancy count.
module aud_sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    pb_reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         level  <= level + LW'(push) - LW'(pop);
      end
   end
   // storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end
   assign dout  = mem[rd_ptr];
   assign full  = level == LW'(DEPTH);
   assign empty = level == '0;
endmodule

// File: rtl/aud_capture_buffer.sv
// aud_capture_buffer: codec sample FIFO drained into sequential RAM writes, with status flags.
// Define AUD_CAPTURE_PEAK_EN to add the peak_abs magnitude tracker output.
module aud_capture_buffer
   import aud_rec_pkg::*;
#(
   parameter int                DATA_W   = AUD_DATA_W,
   parameter int                DEPTH    = 16,
   parameter int                ADDR_W   = RAM_ADDR_W,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic                    clk,
   input  logic                    pb_reset,
   input  logic                    record_en,
   input  logic                    addr_clear,
   input  logic                    sample_valid,
   input  logic [DATA_W-1:0]       sample_in,
   input  logic                    ram_rdy,
   output logic                    ram_we,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       ram_data,
   output logic [ADDR_W-1:0]       cur_addr,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
`ifdef AUD_CAPTURE_PEAK_EN
   output logic [DATA_W-1:0]       peak_abs,
`endif
   output logic                    mem_full
);
   cap_state_t state;
   logic full, empty, pop, push, drop;
   logic [DATA_W-1:0] dout;
   // a full FIFO still accepts a sample when the head leaves in the same cycle
   assign pop  = state == IDLE && !addr_clear && !empty && ram_rdy;
   assign push = sample_valid && record_en && (!full || pop);
   assign drop = sample_valid && record_en && full && !pop;
   aud_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .pb_reset(pb_reset),
      .push(push),
      .pop(pop),
      .din(sample_in),
      .dout(dout),
      .level(level),
      .full(full),
      .empty(empty)
   );
   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         state    <= IDLE;
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_data <= '0;
         cur_addr <= '0;
         overflow <= 1'b0;
         mem_full <= 1'b0;
      end else begin
         if (drop) overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (addr_clear) begin
                  cur_addr <= '0;
                  overflow <= 1'b0;
               end else if (pop) begin
                  ram_we   <= 1'b1;
                  ram_addr <= cur_addr;
                  ram_data <= dout;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               ram_we <= 1'b0;
               if (cur_addr == MAX_ADDR) begin
                  mem_full <= 1'b1;
                  state    <= FULL;
               end else begin
                  cur_addr <= cur_addr + 1'b1;
                  state    <= IDLE;
               end
            end
            FULL: begin
               if (addr_clear) begin
                  cur_addr <= '0;
                  mem_full <= 1'b0;
                  overflow <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef AUD_CAPTURE_PEAK_EN
   logic [DATA_W-1:0] neg, mag;
   assign neg = -sample_in;
   // the most negative code has no positive twin, so it saturates
   assign mag = !sample_in[DATA_W-1] ? sample_in :
                neg[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : neg;
   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) peak_abs <= '0;
      else if (addr_clear && state != ISSUE) peak_abs <= '0;
      else if (push && mag > peak_abs) peak_abs <= mag;
   end
`endif
endmodule

// File: tb/tb_aud_capture_buffer.sv
// tb_aud_capture_buffer: table vectors plus scoreboarded RAM writes for aud_capture_buffer.
module tb_aud_capture_buffer;
   logic clk = 1'b0;
   logic pb_reset = 1'b1;
   logic record_en = 1'b0, addr_clear = 1'b0, sample_valid = 1'b0, ram_rdy = 1'b0;
   logic [15:0] sample_in = '0;
   logic ram_we, overflow, mem_full;
   logic [25:0] ram_addr, cur_addr;
   logic [15:0] ram_data;
   logic [4:0] level;
   logic s_we, s_overflow, s_mem_full;
   logic [25:0] s_ram_addr, s_cur_addr;
   logic [15:0] s_ram_data;
   logic [4:0] s_level;
`ifdef AUD_CAPTURE_PEAK_EN
   logic [15:0] peak_abs, s_peak_abs;
`endif

   typedef struct {logic [25:0] addr; logic [15:0] data;} wr_t;
   typedef struct {logic re, sv, rdy; logic [15:0] d; logic [4:0] lvl; logic we;} vec_t;

   logic [15:0] q[$];
   wr_t qs[$];
   logic [25:0] exp_addr = '0;
   logic small_on = 1'b0;
   int n_checks = 0, n_fail = 0;
   vec_t tbl[13];

   always #5 clk = ~clk;

   aud_capture_buffer u_dut (
      .clk(clk), .pb_reset(pb_reset), .record_en(record_en), .addr_clear(addr_clear),
      .sample_valid(sample_valid), .sample_in(sample_in), .ram_rdy(ram_rdy),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .cur_addr(cur_addr),
      .level(level), .overflow(overflow),
`ifdef AUD_CAPTURE_PEAK_EN
      .peak_abs(peak_abs),
`endif
      .mem_full(mem_full)
   );

   aud_capture_buffer #(.MAX_ADDR(26'd3)) u_small (
      .clk(clk), .pb_reset(pb_reset), .record_en(record_en), .addr_clear(addr_clear),
      .sample_valid(sample_valid), .sample_in(sample_in), .ram_rdy(ram_rdy),
      .ram_we(s_we), .ram_addr(s_ram_addr), .ram_data(s_ram_data), .cur_addr(s_cur_addr),
      .level(s_level), .overflow(s_overflow),
`ifdef AUD_CAPTURE_PEAK_EN
      .peak_abs(s_peak_abs),
`endif
      .mem_full(s_mem_full)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      pb_reset = 1'b1;
      sample_valid = 1'b0;
      addr_clear = 1'b0;
      step();
      pb_reset = 1'b0;
      exp_addr = '0;
      q.delete();
      qs.delete();
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max && q.size() != 0; i++) step();
      check("drain_main", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (ram_we) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", ram_addr, ram_data);
         end else begin
            check("wr_data", ram_data, q.pop_front());
            check("wr_addr", ram_addr, exp_addr);
            exp_addr++;
         end
      end
   end

   always @(negedge clk) begin
      if (small_on && s_we) begin
         if (qs.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL small_wr_unexpected: got write addr %0h, expected none", s_ram_addr);
         end else begin
            wr_t e;
            e = qs.pop_front();
            check("small_wr_addr", s_ram_addr, e.addr);
            check("small_wr_data", s_ram_data, e.data);
         end
      end
   end

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 5'd1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h5555, 5'd0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h00AA, 5'd1, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h00BB, 5'd2, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h00CC, 5'd2, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd2, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd1, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h0000, 5'd0, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_ram_we", ram_we, 0);
      check("rst_cur_addr", cur_addr, 0);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_mem_full", mem_full, 0);
      pb_reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         record_en = tbl[i].re;
         sample_valid = tbl[i].sv;
         sample_in = tbl[i].d;
         ram_rdy = tbl[i].rdy;
         if (tbl[i].re && tbl[i].sv) q.push_back(tbl[i].d);
         step();
         check($sformatf("vec%0d_level", i), level, tbl[i].lvl);
         check($sformatf("vec%0d_ram_we", i), ram_we, tbl[i].we);
      end
      sample_valid = 1'b0;
      check("vec_cur_addr", cur_addr, 4);
      check("vec_overflow", overflow, 0);

      // asynchronous reset while a write is in ISSUE
      sample_in = 16'h4321;
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_ram_we", ram_we, 1);
      pb_reset = 1'b1;
      #1;
      check("mid_rst_ram_we", ram_we, 0);
      check("mid_rst_cur_addr", cur_addr, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_overflow", overflow, 0);
      check("mid_rst_mem_full", mem_full, 0);
      @(negedge clk);
      pb_reset = 1'b0;
      exp_addr = '0;

      // backpressure and overflow
      ram_rdy = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         sample_in = 16'(i);
         sample_valid = 1'b1;
         if (i <= 16) q.push_back(16'(i));
         step();
      end
      sample_valid = 1'b0;
      check("bp_level", level, 16);
      check("bp_overflow", overflow, 1);
      ram_rdy = 1'b1;
      wait_drain(60);
      repeat (2) step();
      check("bp_drained_level", level, 0);
      check("bp_cur_addr", cur_addr, 16);
      check("bp_overflow_sticky", overflow, 1);
      addr_clear = 1'b1;
      exp_addr = '0;
      step();
      addr_clear = 1'b0;
      check("clr_overflow", overflow, 0);
      check("clr_cur_addr", cur_addr, 0);

      // simultaneous push and pop at full
      do_reset();
      ram_rdy = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sample_in = 16'h0100 + 16'(i);
         sample_valid = 1'b1;
         q.push_back(sample_in);
         step();
      end
      sample_valid = 1'b0;
      step();
      check("pp_full_level", level, 16);
      ram_rdy = 1'b1;
      sample_valid = 1'b1;
      sample_in = 16'hABCD;
      q.push_back(16'hABCD);
      step();
      ram_rdy = 1'b0;
      sample_valid = 1'b0;
      check("pp_level", level, 16);
      check("pp_overflow", overflow, 0);
      step();
      check("pp_level_hold", level, 16);
      ram_rdy = 1'b1;
      wait_drain(80);
      repeat (2) step();
      check("pp_cur_addr", cur_addr, 17);
      check("pp_overflow_end", overflow, 0);

      // memory full on the MAX_ADDR=3 instance
      do_reset();
      small_on = 1'b1;
      ram_rdy = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         sample_in = 16'(i);
         sample_valid = 1'b1;
         q.push_back(16'(i));
         if (i <= 4) qs.push_back('{26'(i - 1), 16'(i)});
         step();
      end
      sample_valid = 1'b0;
      wait_drain(40);
      repeat (4) step();
      check("mf_small_writes", qs.size(), 0);
      check("mf_mem_full", s_mem_full, 1);
      check("mf_level", s_level, 2);
      check("mf_cur_addr", s_cur_addr, 3);
      check("mf_main_mem_full", mem_full, 0);
      qs.push_back('{26'd0, 16'd5});
      qs.push_back('{26'd1, 16'd6});
      addr_clear = 1'b1;
      exp_addr = '0;
      step();
      addr_clear = 1'b0;
      check("mf_clr_mem_full", s_mem_full, 0);
      for (int i = 0; i < 20 && qs.size() != 0; i++) step();
      check("mf_small_rewrites", qs.size(), 0);
      repeat (2) step();
      check("mf_clr_cur_addr", s_cur_addr, 2);
      check("mf_clr_level", s_level, 0);
      small_on = 1'b0;

`ifdef AUD_CAPTURE_PEAK_EN
      do_reset();
      ram_rdy = 1'b0;
      check("pk_reset", peak_abs, 0);
      sample_valid = 1'b1;
      sample_in = 16'h0100;
      q.push_back(sample_in);
      step();
      check("pk_0100", peak_abs, 16'h0100);
      sample_in = 16'hFE00;
      q.push_back(sample_in);
      step();
      check("pk_fe00", peak_abs, 16'h0200);
      sample_in = 16'h8000;
      q.push_back(sample_in);
      step();
      check("pk_8000", peak_abs, 16'h7FFF);
      sample_valid = 1'b0;
      ram_rdy = 1'b1;
      wait_drain(20);
      repeat (2) step();
      addr_clear = 1'b1;
      exp_addr = '0;
      step();
      addr_clear = 1'b0;
      check("pk_clear", peak_abs, 0);
`endif

      check("final_queue", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
